// File: rtl/led_pwm_pkg.sv
// Shared types, ASCII constants and the hex-digit decoder for the UART LED PWM controller.
`timescale 1ns/1ps
package led_pwm_pkg;

  typedef enum logic [1:0] {IDLE, HI, LO, RESP} state_e;

  localparam logic [7:0] ACK     = 8'h4B; // 'K'
  localparam logic [7:0] NAK     = 8'h3F; // '?'
  localparam logic [7:0] ALL_OFF = 8'h21; // '!'
  localparam logic [7:0] CH_BASE = 8'h41; // 'A'
  localparam logic [7:0] CR      = 8'h0D;
  localparam logic [7:0] LF      = 8'h0A;

  // Returns {valid, nibble}; valid is clear for anything outside 0-9, A-F, a-f.
  function automatic logic [4:0] hex2nib(input logic [7:0] c);
    logic [4:0] r;
    r = 5'b0;
    if (c >= 8'h30 && c <= 8'h39)      r = {1'b1, c[3:0]};
    else if (c >= 8'h41 && c <= 8'h46) r = {1'b1, c[3:0] + 4'd9};
    else if (c >= 8'h61 && c <= 8'h66) r = {1'b1, c[3:0] + 4'd9};
    return r;
  endfunction

endpackage

// File: rtl/led_pwm_core.sv
// PWM engine: prescaler, free-running counter, shadow/active duty registers
// and registered comparators. Shadows move to active only when the counter wraps.
`timescale 1ns/1ps
module led_pwm_core #(
  parameter int NUM_CH   = 3,
  parameter int DUTY_W   = 8,
  parameter int PRESC    = 1,
  parameter int RST_DUTY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [4:0]        wr_ch,
  input  logic [DUTY_W-1:0] wr_duty,
  input  logic              clr_all,
  output logic [NUM_CH-1:0] pwm_o
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [DUTY_W-1:0] RST_D = DUTY_W'(RST_DUTY);

  logic [PW-1:0]                   presc_q, presc_d;
  logic [DUTY_W-1:0]               cnt_q, cnt_d;
  logic [NUM_CH-1:0][DUTY_W-1:0]   shadow_q, shadow_d;
  logic [NUM_CH-1:0][DUTY_W-1:0]   active_q, active_d;
  logic [NUM_CH-1:0]               pwm_q, pwm_d;
  logic                            tick, wrap;

  assign tick  = (presc_q == PW'(PRESC - 1));
  assign wrap  = tick && (cnt_q == '1);
  assign pwm_o = pwm_q;

  // Next-state for prescaler, counter, duty registers and comparator outputs.
  always_comb begin
    presc_d  = tick ? '0 : presc_q + 1'b1;
    cnt_d    = tick ? cnt_q + 1'b1 : cnt_q;
    shadow_d = shadow_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (clr_all)                          shadow_d[i] = '0;
      else if (wr_en && (wr_ch == 5'(i)))   shadow_d[i] = wr_duty;
    end
    // A write landing on the wrap cycle is picked up one period later.
    active_d = wrap ? shadow_q : active_q;
    for (int i = 0; i < NUM_CH; i++) pwm_d[i] = (cnt_q < active_q[i]);
  end

  // State registers; duties return to the reset duty on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q  <= '0;
      cnt_q    <= '0;
      shadow_q <= {NUM_CH{RST_D}};
      active_q <= {NUM_CH{RST_D}};
      pwm_q    <= '0;
    end else begin
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

endmodule

// File: rtl/uart_led_pwm_ctrl.sv
// ASCII command parser (<ch><hexH><hexL>, '!', CR/LF) driving a multi-channel
// PWM core, with a one-byte acknowledge, idle timeout and saturating error count.
`timescale 1ns/1ps
module uart_led_pwm_ctrl
  import led_pwm_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int DUTY_W      = 8,
  parameter int PRESC       = 1,
  parameter int TIMEOUT_CYC = 1200000,
  parameter int RST_DUTY    = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic [NUM_CH-1:0] pwm_o,
  output logic [7:0]        err_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_e            state_q, state_d;
  logic [4:0]        ch_q, ch_d;
  logic [3:0]        hi_q, hi_d;
  logic [7:0]        txd_q, txd_d;
  logic [7:0]        err_q, err_d;
  logic [TW-1:0]     to_q, to_d;
  logic              alive_q, alive_d;
  logic              accept, ch_ok, nak, wr_en, clr_all;
  logic [4:0]        nib;
  logic [7:0]        byte_val;
  logic [DUTY_W-1:0] wr_duty;

  assign alive_d  = 1'b1;
  assign rx_ready = alive_q && (state_q != RESP);
  assign accept   = rx_valid && rx_ready;
  assign tx_valid = (state_q == RESP);
  assign tx_data  = txd_q;
  assign err_cnt  = err_q;
  assign nib      = hex2nib(rx_data);
  assign ch_ok    = (rx_data >= CH_BASE) && (rx_data < (CH_BASE + 8'(NUM_CH)));
  assign byte_val = {hi_q, nib[3:0]};
  assign wr_duty  = byte_val[7 -: DUTY_W];

  // Parser next-state, response byte, timeout and error counter.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    hi_d    = hi_q;
    txd_d   = txd_q;
    err_d   = err_q;
    to_d    = '0;
    wr_en   = 1'b0;
    clr_all = 1'b0;
    nak     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (ch_ok) begin
            ch_d    = rx_data[4:0] - 5'd1; // 'A' has low bits 00001
            state_d = HI;
          end else if (rx_data == ALL_OFF) begin
            clr_all = 1'b1;
            txd_d   = ACK;
            state_d = RESP;
          end else if (rx_data != CR && rx_data != LF) begin
            txd_d   = NAK;
            nak     = 1'b1;
            state_d = RESP;
          end
        end
      end
      HI, LO: begin
        if (accept) begin
          if (!nib[4]) begin
            txd_d   = NAK;
            nak     = 1'b1;
            state_d = RESP;
          end else if (state_q == HI) begin
            hi_d    = nib[3:0];
            state_d = LO;
          end else begin
            wr_en   = 1'b1;
            txd_d   = ACK;
            state_d = RESP;
          end
        end else if (to_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d = IDLE; // silently drop the partial command
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      RESP: begin
        if (tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (nak && (err_q != 8'hFF)) err_d = err_q + 8'd1;
  end

  // Control registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      ch_q    <= '0;
      hi_q    <= '0;
      txd_q   <= '0;
      err_q   <= '0;
      to_q    <= '0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      hi_q    <= hi_d;
      txd_q   <= txd_d;
      err_q   <= err_d;
      to_q    <= to_d;
      alive_q <= alive_d;
    end
  end

  led_pwm_core #(
    .NUM_CH   (NUM_CH),
    .DUTY_W   (DUTY_W),
    .PRESC    (PRESC),
    .RST_DUTY (RST_DUTY)
  ) u_core (
    .clk     (clk),
    .rst_n   (resetn),
    .wr_en   (wr_en),
    .wr_ch   (ch_q),
    .wr_duty (wr_duty),
    .clr_all (clr_all),
    .pwm_o   (pwm_o)
  );

endmodule

// File: tb/tb_uart_led_pwm_ctrl.sv
// Directed bench for uart_led_pwm_ctrl: expected response bytes are queued when
// a command byte is driven and checked when the DUT hands them over.
`timescale 1ns/1ps
module tb_uart_led_pwm_ctrl;
  import led_pwm_pkg::*;

  localparam int NUM_CH      = 3;
  localparam int DUTY_W      = 8;
  localparam int PRESC       = 1;
  localparam int TIMEOUT_CYC = 50;

  logic              clk = 1'b0;
  logic              resetn;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic [NUM_CH-1:0] pwm_o;
  logic [7:0]        err_cnt;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  int         hi_cnt[NUM_CH];

  uart_led_pwm_ctrl #(
    .NUM_CH      (NUM_CH),
    .DUTY_W      (DUTY_W),
    .PRESC       (PRESC),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .RST_DUTY    (0)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .pwm_o    (pwm_o),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every tx handshake must match the oldest queued response.
  always @(negedge clk) begin
    if (resetn && tx_valid && tx_ready) begin
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL tx_unexpected: observed %0h expected none", tx_data);
      end
      if (exp_q.size() != 0) chk("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
    end
  end

  // Drive one byte; resp < 0 means no reply is expected.
  task automatic send(input logic [7:0] b, input int resp);
    int w;
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    w = 0;
    @(negedge clk);
    while (!rx_ready && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 1000) begin
      chk("rx_ready_timeout", 32'(rx_ready), 32'd1);
      rx_valid = 1'b0;
      return;
    end
    if (resp >= 0) exp_q.push_back(resp[7:0]);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(negedge clk);
    chk("tx_latency", 32'(tx_valid), (resp >= 0) ? 32'd1 : 32'd0);
  endtask

  task automatic measure(input int n);
    for (int c = 0; c < NUM_CH; c++) hi_cnt[c] = 0;
    repeat (n) begin
      @(negedge clk);
      for (int c = 0; c < NUM_CH; c++) if (pwm_o[c]) hi_cnt[c]++;
    end
  endtask

  initial begin
    int  w;
    logic stall_ok;
    resetn   = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b1;

    // Reset values
    #12;
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data",  32'(tx_data),  32'd0);
    chk("rst_err_cnt",  32'(err_cnt),  32'd0);
    chk("rst_pwm",      32'(pwm_o),    32'd0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rx_ready_after_rst", 32'(rx_ready), 32'd1);

    // "B80": 50% on channel 1 only
    send("B", -1); send("8", -1); send("0", ACK);
    repeat (300) @(negedge clk);
    measure(512);
    chk("b80_pwm1", 32'(hi_cnt[1]), 32'd256);
    chk("b80_pwm0", 32'(hi_cnt[0]), 32'd0);
    chk("b80_pwm2", 32'(hi_cnt[2]), 32'd0);

    // "Aff" then "!"
    send("A", -1); send("f", -1); send("f", ACK);
    repeat (300) @(negedge clk);
    measure(256);
    chk("aff_pwm0", 32'(hi_cnt[0]), 32'd255);
    send(ALL_OFF, ACK);
    repeat (300) @(negedge clk);
    measure(256);
    chk("alloff_pwm0", 32'(hi_cnt[0]), 32'd0);
    chk("alloff_pwm1", 32'(hi_cnt[1]), 32'd0);

    // CR/LF ignored in IDLE
    send(LF, -1); send(CR, -1);
    chk("crlf_err", 32'(err_cnt), 32'd0);

    // "D12": out-of-range channel, then two stray digits
    send("D", NAK); send("1", NAK); send("2", NAK);
    chk("d12_err", 32'(err_cnt), 32'd3);

    // "A7g": bad low digit, duty untouched
    send("A", -1); send("7", -1); send("g", NAK);
    chk("a7g_err", 32'(err_cnt), 32'd4);
    for (int i = 0; i < 256; i++) send("x", NAK);
    chk("err_saturate", 32'(err_cnt), 32'd255);
    measure(256);
    chk("a7g_pwm0", 32'(hi_cnt[0]), 32'd0);

    // Timeout discards "C5"; fresh "C40" then works
    send("C", -1); send("5", -1);
    repeat (60) @(negedge clk);
    send("C", -1); send("4", -1); send("0", ACK);
    repeat (300) @(negedge clk);
    measure(256);
    chk("c40_pwm2", 32'(hi_cnt[2]), 32'd64);

    // Gap shorter than the timeout keeps the command alive
    send("B", -1); send("4", -1);
    repeat (30) @(negedge clk);
    send("0", ACK);
    repeat (300) @(negedge clk);
    measure(256);
    chk("gap_pwm1", 32'(hi_cnt[1]), 32'd64);

    // tx stall with a byte waiting on rx
    tx_ready = 1'b0;
    send("A", -1); send("1", -1); send("0", ACK);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = "z";
    stall_ok = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (!(tx_valid && !rx_ready && tx_data == ACK)) stall_ok = 1'b0;
    end
    chk("stall_hold", 32'(stall_ok), 32'd1);
    chk("stall_pending", 32'(exp_q.size()), 32'd1);
    exp_q.push_back(NAK);
    @(posedge clk); #1 tx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("stall_rx_ready", 32'(rx_ready), 32'd1);
    @(posedge clk); #1 rx_valid = 1'b0;
    @(negedge clk);
    chk("stall_z_resp", 32'(tx_valid), 32'd1);
    @(negedge clk);
    chk("stall_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset in the middle of "A1"
    send("A", -1); send("1", -1);
    w = 0;
    while (!pwm_o[2] && w < 600) begin
      @(negedge clk);
      w++;
    end
    chk("pwm2_seen", 32'(pwm_o[2]), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("mid_rst_tx_data",  32'(tx_data),  32'd0);
    chk("mid_rst_err",      32'(err_cnt),  32'd0);
    chk("mid_rst_pwm",      32'(pwm_o),    32'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    // The partial "A1" is gone: a lone '0' in IDLE is rejected
    send("0", NAK);
    chk("post_rst_err", 32'(err_cnt), 32'd1);
    send("B", -1); send("8", -1); send("0", ACK);
    repeat (300) @(negedge clk);
    measure(512);
    chk("post_rst_pwm1", 32'(hi_cnt[1]), 32'd256);
    chk("post_rst_pwm2", 32'(hi_cnt[2]), 32'd0);

    repeat (4) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_led_pwm_ctrl.md
Name: uart_led_pwm_ctrl

Overview:
- Parametrised successor to the on/off UART LED selector: parses an ASCII byte stream into per-channel PWM duty values, drives NUM_CH PWM outputs, and returns a one-byte acknowledge per command.
- Sits between the UART byte interface (rx/tx valid-ready, adapted from the simpleuart register port at top level) and the SB_RGBA_DRV PWM inputs, or any LED/PWM sink.

Parameters:
- NUM_CH, 3, number of PWM channels (1..26); channel i is addressed by ASCII 'A'+i.
- DUTY_W, 8, duty/counter width (1..8); the duty is the top DUTY_W bits of the received 8-bit hex value.
- PRESC, 1, PWM counter advances once every PRESC clk cycles (>=1).
- TIMEOUT_CYC, 1200000, idle cycles after which a partial command is discarded (>=2).
- RST_DUTY, 0, reset duty loaded into every channel.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- rx_valid  in  1  received byte valid.
- rx_data  in  8  received byte.
- rx_ready  out  1  parser accepts a byte this cycle.
- tx_valid  out  1  response byte valid.
- tx_data  out  8  response byte: 'K' (0x4B) or '?' (0x3F).
- tx_ready  in  1  sink accepts tx_data.
- pwm_o  out  NUM_CH  active-high PWM per channel.
- err_cnt  out  8  saturating count of rejected commands.

Behaviour:
- Reset (async, resetn=0):
  - State is IDLE; rx_ready=0 during reset, then 1 from the first cycle after release.
  - tx_valid=0, tx_data=0, err_cnt=0, pwm counter=0, prescaler=0.
  - Active and shadow duty = RST_DUTY[DUTY_W-1:0]; pwm_o = 0 when RST_DUTY=0.
- Byte transfer happens when rx_valid && rx_ready. rx_ready=1 in IDLE/HI/LO and 0 in RESP.
- Command grammar: <ch><hexH><hexL>.
  - ch = 'A'..'A'+NUM_CH-1.
  - Hex digits are '0'-'9', 'A'-'F', 'a'-'f'.
  - Single byte '!' sets all shadow duties to 0 and replies 'K'.
  - CR (0x0D) and LF (0x0A) are ignored in IDLE with no reply.
- State machine:
  - IDLE:
    - Valid channel letter: latch the channel index, go to HI.
    - '!': clear all shadows, go to RESP('K').
    - CR/LF: stay in IDLE.
    - Any other byte: go to RESP('?').
  - HI: hex digit: latch the high nibble, go to LO. Non-hex: go to RESP('?').
  - LO: hex digit: write shadow[ch] = {H,L}[7:8-DUTY_W], go to RESP('K'). Non-hex: go to RESP('?').
  - RESP:
    - tx_valid=1 with tx_data stable until tx_ready.
    - On the tx_valid&&tx_ready cycle, deassert tx_valid and return to IDLE.
    - Latency from the accepting rx beat to tx_valid: 1 cycle.
- Errors: each '?' response increments err_cnt, which saturates at 255 (no wrap).
- Timeout: in HI or LO, an idle counter resets on every accepted byte. At TIMEOUT_CYC cycles it forces IDLE, sends no response, and leaves the shadow unchanged. The timeout is not counted as an error.
- PWM:
  - The DUTY_W-bit counter increments on each prescaler tick and wraps from 2^DUTY_W-1 to 0.
  - pwm_o[i] = (cnt < duty[i]), registered, so it lags the counter by 1 cycle.
  - duty=0 gives constant low; duty=2^DUTY_W-1 gives high except 1 tick per period.
- Glitch-free update:
  - Shadow-to-active copy occurs only on the tick where cnt wraps to 0.
  - If a shadow write and the wrap happen in the same cycle, the new value is used from the next period.
- Reset mid-command or mid-RESP discards the partial command and the pending byte. Duties return to RST_DUTY.
- Holding tx_ready=0 stalls indefinitely in RESP. rx is back-pressured meanwhile; bytes are not dropped.

Decomposition:
- Package led_pwm_pkg holds:
  - The state enum (IDLE, HI, LO, RESP).
  - ASCII constants ACK='K', NAK='?', ALL_OFF='!', CH_BASE='A', CR, LF.
  - A function hex2nib returning {valid, nibble}.
- Sub-module led_pwm_core (parameters NUM_CH, DUTY_W, PRESC): prescaler, counter, shadow/active duty registers and comparators. Inputs: shadow write-enable, channel index, duty value and all-clear.
- The top-level uart_led_pwm_ctrl holds the parser FSM, the timeout counter and err_cnt.

Test Plan:
- Release reset, then send "B80" (NUM_CH=3, DUTY_W=8, PRESC=1) -> tx 'K' 1 cycle after the '0' beat. From the next wrap, pwm_o[1] is high for 128 of 256 cycles; pwm_o[0] and pwm_o[2] stay 0.
- Send "Aff", then "!" -> 'K','K'. pwm_o[0] is high 255/256 for one period, then constant 0 from the following wrap.
- Send "D12" (D out of range) -> '?' after 'D', err_cnt=1. Then '1' and '2' are each rejected -> two more '?', err_cnt=3. No duty change.
- Send "A" then "7g" -> '?' on 'g', duty unchanged. Send 256 bad bytes -> err_cnt saturates at 255.
- Send "C5" and idle for TIMEOUT_CYC (set to 50) -> no tx, state back to IDLE. Then "C40" -> 'K', and duty[2]=0x40 (DUTY_W=4 build: duty=4).
- Hold tx_ready=0 after "A10": tx_valid held and rx_ready=0 for 100 cycles. Then tx_ready=1 -> single 'K' handshake. Assert resetn=0 mid-"A1" -> all outputs at reset values asynchronously.
